// File: rtl/ram_16x8_if.sv
// Bus bundle for the SAP-1 program/data RAM: run-mode read port plus the
// valid/ready bulk-load stream used in programming mode.
interface ram_16x8_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] RAM_addr;
  logic              CE;
  logic [DATA_W-1:0] RAM_out;
  logic              ram_oe;
  logic              prog;
  logic              ld_start;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              ld_done;

  modport master (
    output RAM_addr, CE, prog, ld_start, ld_valid, ld_data,
    input  RAM_out, ram_oe, ld_ready, ld_done
  );

  modport slave (
    input  RAM_addr, CE, prog, ld_start, ld_valid, ld_data,
    output RAM_out, ram_oe, ld_ready, ld_done
  );
endinterface

// File: rtl/ram_16x8.sv
// SAP-1 16x8 RAM with registered read port and a stream bulk loader.
// Define RAM_INIT_EN to make reset load the demo program instead of zeros.
module ram_16x8 #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input logic       clk,
  input logic       clr,
  ram_16x8_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              start;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data_p1;
  logic              vld_p1;

`ifdef RAM_INIT_EN
  // LDA 9, ADD A, ADD B, SUB C, OUT, HLT followed by its operands.
  function automatic logic [DATA_W-1:0] init_word(input int unsigned a);
    logic [DATA_W-1:0] w;
    case (a)
      0:       w = DATA_W'(8'h09);
      1:       w = DATA_W'(8'h1A);
      2:       w = DATA_W'(8'h1B);
      3:       w = DATA_W'(8'h2C);
      4:       w = DATA_W'(8'hE0);
      5:       w = DATA_W'(8'hF0);
      9:       w = DATA_W'(8'h10);
      10:      w = DATA_W'(8'h14);
      11:      w = DATA_W'(8'h18);
      12:      w = DATA_W'(8'h20);
      default: w = '0;
    endcase
    return w;
  endfunction
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    unique case (state_q)
      IDLE: if (bus.prog && bus.ld_start) begin
        state_d = LOAD;
        start   = 1'b1;
      end
      LOAD: begin
        if (!bus.prog)                       state_d = IDLE;
        else if (bus.ld_valid && (&ptr_q))   state_d = DONE;
      end
      DONE: if (!bus.prog) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Writes are qualified by prog so a read and a write can never share a cycle.
  assign bus.ld_ready = (state_q == LOAD) && bus.prog;
  assign bus.ld_done  = (state_q == DONE);
  assign wr_en        = bus.ld_ready && bus.ld_valid;
  assign rd_en        = !bus.prog && !bus.CE;

  always_ff @(posedge clk or posedge clr) begin
    if (clr)        ptr_q <= '0;
    else if (start) ptr_q <= '0;
    else if (wr_en) ptr_q <= ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
`ifdef RAM_INIT_EN
        mem[i] <= init_word(i);
`else
        mem[i] <= '0;
`endif
      end
    end else if (wr_en) begin
      mem[ptr_q] <= bus.ld_data;
    end
  end

  // p1: registered read, one cycle after address/CE
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      rd_data_p1 <= rd_en ? mem[bus.RAM_addr] : '0;
      vld_p1     <= rd_en;
    end
  end

  assign bus.RAM_out = rd_data_p1;
  assign bus.ram_oe  = vld_p1;
endmodule
